// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
//   Shared definitions for the ping-pong game: ball controller state
//   encodings and the default playfield geometry. The VGA renderer and the
//   PIO wiring use the same constants.
// ---------------------------------------------------------------------------
package pong_pkg;

  // Ball controller phases. The encodings are visible to the CPU through
  // the state port, so they are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_MOVE  = 2'd2,
    ST_SCORE = 2'd3
  } pong_state_e;

  // Default playfield geometry.
  localparam int PONG_X_W      = 6;   // ball column width
  localparam int PONG_Y_W      = 5;   // ball / paddle row width
  localparam int PONG_X_MAX    = 63;  // right paddle column (left paddle is 0)
  localparam int PONG_Y_MAX    = 31;  // bottom row
  localparam int PONG_PADDLE_H = 6;   // paddle height in rows

endpackage : pong_pkg

// File: rtl/pong_tick_gen.sv
// ---------------------------------------------------------------------------
// pong_tick_gen
//   Motion tick divider. Counts 0..TICK_DIV-1 while enabled and emits a
//   one-cycle tick on the terminal count, then wraps. A clear holds the
//   count at 0. While disabled and not cleared the count is frozen, which
//   is how a pause keeps the phase of the next tick.
// Ports
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   i_en     in  count enable
//   i_clr    in  synchronous clear (has priority over i_en)
//   o_tick   out one-cycle pulse on the terminal count while enabled
// ---------------------------------------------------------------------------
module pong_tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_LAST);
  assign o_tick = i_en && !i_clr && w_last;

  // NOTE: asynchronous reset lives in the sensitivity list; every register
  // here is state, so it is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule : pong_tick_gen

// File: rtl/pong_ball_ctrl.sv
// ---------------------------------------------------------------------------
// pong_ball_ctrl
//   Ball motion sequencer. Steps the ball one cell per motion tick, bounces
//   it off the top/bottom walls and the paddles, detects misses and runs
//   the IDLE -> SERVE -> MOVE -> SCORE -> SERVE game phases. o_frame_strobe
//   marks the cycle in which the coordinates of a tick update are first
//   visible, so the CPU can read a coherent (x, y) pair.
// Ports
//   clk             in  system clock
//   reset_n         in  asynchronous active-low reset
//   i_start         in  pulse, starts a game from IDLE
//   i_pause         in  level, freezes the divider and all state
//   i_paddle_l_y    in  top row of the left paddle
//   i_paddle_r_y    in  top row of the right paddle
//   o_ball_x        out ball column
//   o_ball_y        out ball row
//   o_dir_x         out 1 = moving right
//   o_dir_y         out 1 = moving down
//   o_state         out game phase (pong_state_e encoding)
//   o_score_l       out one-cycle pulse, left player scored
//   o_score_r       out one-cycle pulse, right player scored
//   o_frame_strobe  out one-cycle pulse after every tick-driven update
// ---------------------------------------------------------------------------
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int X_W         = PONG_X_W,
  parameter int Y_W         = PONG_Y_W,
  parameter int X_MAX       = PONG_X_MAX,
  parameter int Y_MAX       = PONG_Y_MAX,
  parameter int PADDLE_H    = PONG_PADDLE_H,
  parameter int TICK_DIV    = 1000000,
  parameter int SERVE_DELAY = 25
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_start,
  input  logic           i_pause,
  input  logic [Y_W-1:0] i_paddle_l_y,
  input  logic [Y_W-1:0] i_paddle_r_y,
  output logic [X_W-1:0] o_ball_x,
  output logic [Y_W-1:0] o_ball_y,
  output logic           o_dir_x,
  output logic           o_dir_y,
  output logic [1:0]     o_state,
  output logic           o_score_l,
  output logic           o_score_r,
  output logic           o_frame_strobe
);

  localparam int SC_W = $clog2(SERVE_DELAY + 1);

  localparam logic [X_W-1:0]  X_CENTRE   = X_W'(X_MAX >> 1);
  localparam logic [Y_W-1:0]  Y_CENTRE   = Y_W'(Y_MAX >> 1);
  localparam logic [X_W-1:0]  X_RIGHT    = X_W'(X_MAX);
  localparam logic [X_W-1:0]  X_R_HIT    = X_W'(X_MAX - 1);  // column in front of right paddle
  localparam logic [X_W-1:0]  X_R_BOUNCE = X_W'(X_MAX - 2);
  localparam logic [Y_W-1:0]  Y_BOTTOM   = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0]  Y_BOUNCE   = Y_W'(Y_MAX - 1);
  localparam logic [SC_W-1:0] SERVE_LAST = SC_W'(SERVE_DELAY - 1);

  // Paddle coverage test. The bottom row is formed one bit wider than the
  // row so a paddle near the bottom edge cannot wrap round to row 0.
  function automatic logic in_paddle(input logic [Y_W-1:0] y,
                                     input logic [Y_W-1:0] top);
    logic [Y_W:0] bottom;
    bottom = {1'b0, top} + (Y_W+1)'(PADDLE_H - 1);
    return ({1'b0, y} >= {1'b0, top}) && ({1'b0, y} <= bottom);
  endfunction

  pong_state_e     r_state,     w_state_nxt;
  logic [X_W-1:0]  r_x,         w_x_nxt;
  logic [Y_W-1:0]  r_y,         w_y_nxt;
  logic            r_dx,        w_dx_nxt;
  logic            r_dy,        w_dy_nxt;
  logic [SC_W-1:0] r_serve_cnt, w_serve_cnt_nxt;
  logic            r_score_l,   w_score_l_nxt;
  logic            r_score_r,   w_score_r_nxt;
  logic            r_strobe;
  logic            w_tick;

  // The divider is cleared in IDLE and frozen, not cleared, while paused.
  pong_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (!i_pause && (r_state != ST_IDLE)),
    .i_clr   (r_state == ST_IDLE),
    .o_tick  (w_tick)
  );

  // Next-state and datapath. Outside IDLE every change is qualified by
  // w_tick, which is already low while paused.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_dx_nxt        = r_dx;
    w_dy_nxt        = r_dy;
    w_serve_cnt_nxt = r_serve_cnt;
    w_score_l_nxt   = 1'b0;
    w_score_r_nxt   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // Pause freezes everything, including leaving IDLE.
        if (i_start && !i_pause) begin
          w_state_nxt     = ST_SERVE;
          w_serve_cnt_nxt = '0;
        end
      end

      ST_SERVE: begin
        if (w_tick) begin
          if (r_serve_cnt == SERVE_LAST) begin
            w_state_nxt = ST_MOVE;
          end else begin
            w_serve_cnt_nxt = r_serve_cnt + SC_W'(1);
          end
        end
      end

      ST_MOVE: begin
        if (w_tick) begin
          // Vertical: walls reflect the ball back into the field.
          if (r_dy && (r_y == Y_BOTTOM)) begin
            w_y_nxt  = Y_BOUNCE;
            w_dy_nxt = 1'b0;
          end else if (!r_dy && (r_y == '0)) begin
            w_y_nxt  = Y_W'(1);
            w_dy_nxt = 1'b1;
          end else begin
            w_y_nxt  = r_dy ? r_y + Y_W'(1) : r_y - Y_W'(1);
          end

          // Horizontal: the paddle test uses the row before this tick's move.
          if (r_dx && (r_x == X_R_HIT)) begin
            if (in_paddle(r_y, i_paddle_r_y)) begin
              w_x_nxt  = X_R_BOUNCE;
              w_dx_nxt = 1'b0;
            end else begin
              w_x_nxt       = X_RIGHT;
              w_score_l_nxt = 1'b1;
              w_state_nxt   = ST_SCORE;
            end
          end else if (!r_dx && (r_x == X_W'(1))) begin
            if (in_paddle(r_y, i_paddle_l_y)) begin
              w_x_nxt  = X_W'(2);
              w_dx_nxt = 1'b1;
            end else begin
              w_x_nxt       = '0;
              w_score_r_nxt = 1'b1;
              w_state_nxt   = ST_SCORE;
            end
          end else begin
            w_x_nxt = r_dx ? r_x + X_W'(1) : r_x - X_W'(1);
          end
        end
      end

      ST_SCORE: begin
        if (w_tick) begin
          // The ball still sits in the miss column, which tells us who
          // conceded: serve toward that side.
          w_dx_nxt        = (r_x == X_RIGHT);
          w_dy_nxt        = 1'b1;
          w_x_nxt         = X_CENTRE;
          w_y_nxt         = Y_CENTRE;
          w_serve_cnt_nxt = '0;
          w_state_nxt     = ST_SERVE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_x         <= X_CENTRE;
      r_y         <= Y_CENTRE;
      r_dx        <= 1'b1;
      r_dy        <= 1'b1;
      r_serve_cnt <= '0;
      r_score_l   <= 1'b0;
      r_score_r   <= 1'b0;
      r_strobe    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_dx        <= w_dx_nxt;
      r_dy        <= w_dy_nxt;
      r_serve_cnt <= w_serve_cnt_nxt;
      r_score_l   <= w_score_l_nxt;
      r_score_r   <= w_score_r_nxt;
      // Rises together with the updated coordinates, one cycle after tick.
      r_strobe    <= w_tick;
    end
  end

  assign o_ball_x       = r_x;
  assign o_ball_y       = r_y;
  assign o_dir_x        = r_dx;
  assign o_dir_y        = r_dy;
  assign o_state        = r_state;
  assign o_score_l      = r_score_l;
  assign o_score_r      = r_score_r;
  assign o_frame_strobe = r_strobe;

endmodule : pong_ball_ctrl

// File: tb/tb_pong_ball_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_ball_ctrl
//   Directed bench for pong_ball_ctrl with TICK_DIV=4, SERVE_DELAY=3.
//   The ball trajectory from the centre is deterministic, so the expected
//   positions at chosen tick numbers are worked out by hand below.
// ---------------------------------------------------------------------------
module tb_pong_ball_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [4:0] paddle_l_y = '0;
  logic [4:0] paddle_r_y = '0;
  logic [5:0] ball_x;
  logic [4:0] ball_y;
  logic       dir_x, dir_y;
  logic [1:0] state;
  logic       score_l, score_r, frame_strobe;

  int checks = 0;
  int errors = 0;

  pong_ball_ctrl #(
    .TICK_DIV    (4),
    .SERVE_DELAY (3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_start        (start),
    .i_pause        (pause),
    .i_paddle_l_y   (paddle_l_y),
    .i_paddle_r_y   (paddle_r_y),
    .o_ball_x       (ball_x),
    .o_ball_y       (ball_y),
    .o_dir_x        (dir_x),
    .o_dir_y        (dir_y),
    .o_state        (state),
    .o_score_l      (score_l),
    .o_score_r      (score_r),
    .o_frame_strobe (frame_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_ball(input string tag, input int x, input int y,
                            input int dx, input int dy, input int st);
    check({tag, ".x"},     ball_x, x);
    check({tag, ".y"},     ball_y, y);
    check({tag, ".dir_x"}, dir_x,  dx);
    check({tag, ".dir_y"}, dir_y,  dy);
    check({tag, ".state"}, state,  st);
  endtask

  // Waits for n frame strobes, sampling on falling edges. cyc returns the
  // number of cycles the last wait took. A missing strobe is a failure.
  task automatic wait_strobes(input string tag, input int n, output int cyc);
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!frame_strobe && cyc < 40);
      if (!frame_strobe) begin
        check({tag, ".strobe_timeout"}, 0, 1);
        return;
      end
    end
  endtask

  initial begin
    int cyc;
    int k;
    logic seen;

    // 1: reset values, then a quiet IDLE.
    repeat (3) @(negedge clk);
    check_ball("reset", 31, 15, 1, 1, 0);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (score_l || score_r || frame_strobe || state != 2'd0 ||
          ball_x != 6'd31 || ball_y != 5'd15) seen = 1'b1;
    end
    check("idle_quiet", seen, 0);

    // 2: start -> SERVE, three ticks -> MOVE, first move one cell diagonally.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start.state", state, 1);
    wait_strobes("serve", 2, cyc);
    check("serve2.state", state, 1);
    wait_strobes("serve", 1, cyc);
    check_ball("serve3", 31, 15, 1, 1, 2);

    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ball_x == 6'd31 && k < 40);
    check("move1.strobe", frame_strobe, 1);
    check_ball("move1", 32, 16, 1, 1, 2);
    @(negedge clk);
    check("move1.strobe_width", frame_strobe, 0);

    // Tick spacing must be TICK_DIV clocks.
    wait_strobes("move2", 1, cyc);
    wait_strobes("move3", 1, cyc);
    check("tick_period", cyc, 4);
    check_ball("move3", 34, 18, 1, 1, 2);

    // 3: bottom wall. Tick 16 reaches y=31, tick 17 reflects.
    wait_strobes("move16", 13, cyc);
    check_ball("move16", 47, 31, 1, 1, 2);
    wait_strobes("move17", 1, cyc);
    check_ball("move17", 48, 30, 1, 0, 2);

    // 6a: pause for ten tick periods mid-MOVE.
    wait_strobes("move20", 3, cyc);
    check_ball("move20", 51, 27, 1, 0, 2);
    pause = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_strobe || ball_x != 6'd51 || ball_y != 5'd27) seen = 1'b1;
    end
    check("pause.frozen", seen, 0);
    check_ball("pause", 51, 27, 1, 0, 2);
    pause = 1'b0;

    // 4: right paddle hit with y on the paddle's bottom row (11..16).
    paddle_r_y = 5'd11;
    wait_strobes("move31", 11, cyc);
    check_ball("move31", 62, 16, 1, 0, 2);
    wait_strobes("move32", 1, cyc);
    check_ball("rhit", 61, 15, 0, 0, 2);
    check("rhit.score_l", score_l, 0);

    // Top wall: tick 47 reaches y=0, tick 48 reflects.
    wait_strobes("move47", 15, cyc);
    check_ball("move47", 46, 0, 0, 0, 2);
    wait_strobes("move48", 1, cyc);
    check_ball("move48", 45, 1, 0, 1, 2);

    // 5 mirror: left miss, y=17 just above paddle rows 18..23.
    paddle_l_y = 5'd18;
    wait_strobes("move92", 44, cyc);
    check_ball("move92", 1, 17, 0, 0, 2);
    wait_strobes("lmiss", 1, cyc);
    check_ball("lmiss", 0, 16, 0, 0, 3);
    check("lmiss.score_r", score_r, 1);
    check("lmiss.score_l", score_l, 0);
    @(negedge clk);
    check("lmiss.score_r_width", score_r, 0);
    wait_strobes("lrecentre", 1, cyc);
    check_ball("lrecentre", 31, 15, 0, 1, 1);

    // Second rally, serving left. Left paddle hit on its top row (17).
    paddle_l_y = 5'd17;
    wait_strobes("r2serve", 3, cyc);
    check_ball("r2serve", 31, 15, 0, 1, 2);
    wait_strobes("r2m16", 16, cyc);
    check_ball("r2m16", 15, 31, 0, 1, 2);
    wait_strobes("r2m30", 14, cyc);
    check_ball("r2m30", 1, 17, 0, 0, 2);
    wait_strobes("lhit", 1, cyc);
    check_ball("lhit", 2, 16, 1, 0, 2);
    check("lhit.score_r", score_r, 0);

    // 5: right miss, y=18 just above paddle rows 19..24.
    paddle_r_y = 5'd19;
    wait_strobes("r2m91", 60, cyc);
    check_ball("r2m91", 62, 18, 1, 0, 2);
    wait_strobes("rmiss", 1, cyc);
    check_ball("rmiss", 63, 17, 1, 0, 3);
    check("rmiss.score_l", score_l, 1);
    check("rmiss.score_r", score_r, 0);
    @(negedge clk);
    check("rmiss.score_l_width", score_l, 0);
    check("rmiss.hold_x", ball_x, 63);
    wait_strobes("rrecentre", 1, cyc);
    check_ball("rrecentre", 31, 15, 1, 1, 1);

    // 6b: reset in the middle of MOVE takes effect without a clock edge.
    wait_strobes("r3serve", 3, cyc);
    wait_strobes("r3m1", 1, cyc);
    check_ball("r3m1", 32, 16, 1, 1, 2);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_ball("async_reset", 31, 15, 1, 1, 0);
    check("async_reset.strobe", frame_strobe, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state != 2'd0 || frame_strobe) seen = 1'b1;
    end
    check("post_reset_idle", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pong_ball_ctrl
